// File: rtl/map_tile_writer_if.sv
// Request/write-port bundle for map_tile_writer: rectangle-fill requests in,
// map RAM write strobes and status out.
interface map_tile_writer_if;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_x;
    logic [7:0]  req_y;
    logic [4:0]  req_w;
    logic [4:0]  req_h;
    logic [1:0]  req_color;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [1:0]  wr_data;
    logic        busy;
    logic        done;

    modport slave (
        input  req_valid, req_x, req_y, req_w, req_h, req_color,
        output req_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport master (
        output req_valid, req_x, req_y, req_w, req_h, req_color,
        input  req_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/map_tile_writer.sv
// Queues rectangle-fill requests and writes one 2-bit pixel per clock into the
// map RAM write port, clipping pixels that fall outside the map.
module map_tile_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAP_W      = 320,
    parameter int MAP_H      = 240
) (
    input  logic              vga_clk,
    input  logic              reset,
    map_tile_writer_if.slave  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [4:0] w;
        logic [4:0] h;
        logic [1:0] c;
    } req_t;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    req_t          fifo_q [FIFO_DEPTH];
    req_t          fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q, state_d;
    req_t          cur_q, cur_d;
    logic [4:0]    xo_q, xo_d, yo_q, yo_d;
    logic          wr_en_q, wr_en_d;
    logic [16:0]   wr_addr_q, wr_addr_d;
    logic [1:0]    wr_data_q, wr_data_d;

    logic          fifo_full, fifo_empty, push, pop;
    logic [9:0]    x_sum;
    logic [8:0]    y_sum;
    logic          in_bounds, last_col, last_row;
    logic [16:0]   pix_addr;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A full queue refuses a push even when a pop frees a slot on the same edge.
    assign push       = bus.req_valid && !fifo_full;
    assign pop        = (state_q == IDLE) && !fifo_empty;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{x: bus.req_x, y: bus.req_y, w: bus.req_w,
                                 h: bus.req_h, c: bus.req_color};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign x_sum     = {1'b0, cur_q.x} + 10'(xo_q);
    assign y_sum     = {1'b0, cur_q.y} + 9'(yo_q);
    assign in_bounds = (x_sum < 10'(MAP_W)) && (y_sum < 9'(MAP_H));
    assign pix_addr  = 17'(y_sum) * 17'(MAP_W) + 17'(x_sum);
    assign last_col  = (xo_q == cur_q.w - 5'd1);
    assign last_row  = (yo_q == cur_q.h - 5'd1);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        xo_d      = xo_q;
        yo_d      = yo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    cur_d   = fifo_q[rd_ptr_q];
                    xo_d    = '0;
                    yo_d    = '0;
                    state_d = (fifo_q[rd_ptr_q].w == '0 || fifo_q[rd_ptr_q].h == '0)
                              ? DONE : FILL;
                end
            end
            FILL: begin
                // Clipped pixels still take their cycle so timing is w*h regardless.
                wr_en_d   = in_bounds;
                wr_addr_d = pix_addr;
                wr_data_d = cur_q.c;
                if (last_col) begin
                    xo_d = '0;
                    yo_d = yo_q + 5'd1;
                    if (last_row)
                        state_d = DONE;
                end else begin
                    xo_d = xo_q + 5'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            cur_q     <= '0;
            xo_q      <= '0;
            yo_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            xo_q      <= xo_d;
            yo_q      <= yo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Queue storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge vga_clk) begin
        fifo_q <= fifo_d;
    end

    assign bus.req_ready = !fifo_full;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_map_tile_writer.sv
// Directed self-checking bench for map_tile_writer: fills, clipping, empty
// rectangles, back-pressure, reset mid-fill and simultaneous push/pop.
module tb_map_tile_writer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    logic [16:0] done_addr;
    logic        done_wen;
    logic [18:0] wq[$];

    map_tile_writer_if bif ();

    map_tile_writer #(.FIFO_DEPTH(4), .MAP_W(320), .MAP_H(240)) dut (
        .vga_clk (clk),
        .reset   (rst),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    // Write/done log sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bif.wr_en) wq.push_back({bif.wr_addr, bif.wr_data});
        if (bif.done) begin
            done_cnt  <= done_cnt + 1;
            done_addr <= bif.wr_addr;
            done_wen  <= bif.wr_en;
        end
    end

    function automatic logic [18:0] ent(input int addr, input int data);
        return {17'(addr), 2'(data)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int x, input int y, input int w, input int h, input int c);
        bif.req_x     = 9'(x);
        bif.req_y     = 8'(y);
        bif.req_w     = 5'(w);
        bif.req_h     = 5'(h);
        bif.req_color = 2'(c);
    endtask

    task automatic send(input int x, input int y, input int w, input int h, input int c);
        int g = 0;
        set_req(x, y, w, h, c);
        bif.req_valid = 1'b1;
        while (!bif.req_ready && g < 3000) begin tick(); g++; end
        chk("send_ready", 32'(bif.req_ready), 1);
        tick();
        bif.req_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin tick(); n++; end while (!bif.done && n < 200);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int g = 0;
        while (bif.busy && g < budget) begin tick(); g++; end
        chk(tag, 32'(bif.busy), 0);
    endtask

    initial begin
        int n, d0, sent, g;
        bit stall_seen;

        rst = 1'b1;
        bif.req_valid = 1'b0;
        set_req(0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_wr_en",   32'(bif.wr_en), 0);
        chk("rst_wr_addr", 32'(bif.wr_addr), 0);
        chk("rst_wr_data", 32'(bif.wr_data), 0);
        chk("rst_done",    32'(bif.done), 0);
        chk("rst_busy",    32'(bif.busy), 0);
        rst = 1'b0;
        tick();
        chk("rst_ready",   32'(bif.req_ready), 1);

        // 1: basic 2x2 fill with latency check
        wq.delete(); d0 = done_cnt;
        send(10, 20, 2, 2, 3);
        tick();
        chk("t1_pop_wr_en", 32'(bif.wr_en), 0);
        chk("t1_pop_busy",  32'(bif.busy), 1);
        tick();
        chk("t1_first_wr_en",   32'(bif.wr_en), 1);
        chk("t1_first_wr_addr", 32'(bif.wr_addr), 6410);
        chk("t1_first_wr_data", 32'(bif.wr_data), 3);
        wait_idle("t1_idle", 50);
        chk("t1_nwr", wq.size(), 4);
        if (wq.size() == 4) begin
            chk("t1_w0", 32'(wq[0]), 32'(ent(6410, 3)));
            chk("t1_w1", 32'(wq[1]), 32'(ent(6411, 3)));
            chk("t1_w2", 32'(wq[2]), 32'(ent(6730, 3)));
            chk("t1_w3", 32'(wq[3]), 32'(ent(6731, 3)));
        end
        chk("t1_done_cnt",  32'(done_cnt - d0), 1);
        chk("t1_done_addr", 32'(done_addr), 6731);
        chk("t1_done_wen",  32'(done_wen), 1);

        // 2: corner clipping, 6 fill cycles, one in-bounds write
        wq.delete(); d0 = done_cnt;
        send(319, 239, 3, 2, 1);
        wait_done(n);
        chk("t2_done_latency", n, 7);
        wait_idle("t2_idle", 50);
        chk("t2_nwr", wq.size(), 1);
        if (wq.size() == 1) chk("t2_w0", 32'(wq[0]), 32'(ent(76799, 1)));
        chk("t2_done_cnt", 32'(done_cnt - d0), 1);

        // 3: zero-width request goes straight to DONE
        wq.delete(); d0 = done_cnt;
        send(5, 5, 0, 5, 2);
        chk("t3_done_early", 32'(bif.done), 0);
        tick();
        chk("t3_done_pulse", 32'(bif.done), 1);
        tick();
        chk("t3_done_fall", 32'(bif.done), 0);
        wait_idle("t3_idle", 20);
        chk("t3_nwr", wq.size(), 0);
        chk("t3_done_cnt", 32'(done_cnt - d0), 1);

        // 4: back-pressure during a 31x31 fill
        wq.delete(); d0 = done_cnt;
        send(0, 0, 31, 31, 1);
        sent = 0; g = 0; stall_seen = 0;
        set_req(100, 5, 1, 1, 0);
        bif.req_valid = 1'b1;
        while (sent < 6 && g < 4000) begin
            n = int'(bif.req_ready);
            if (n == 0 && !stall_seen) begin
                stall_seen = 1;
                chk("t4_stall_at", sent, 4);
            end
            tick(); g++;
            if (n != 0) begin
                sent++;
                set_req(100 + sent, 5, 1, 1, sent % 4);
            end
        end
        bif.req_valid = 1'b0;
        chk("t4_sent", sent, 6);
        chk("t4_stalled", 32'(stall_seen), 1);
        wait_idle("t4_idle", 300);
        chk("t4_done_cnt", 32'(done_cnt - d0), 7);
        chk("t4_nwr", wq.size(), 967);
        if (wq.size() == 967) begin
            chk("t4_big_first", 32'(wq[0]), 32'(ent(0, 1)));
            chk("t4_big_last",  32'(wq[960]), 32'(ent(9630, 1)));
            for (int i = 0; i < 6; i++)
                chk($sformatf("t4_small%0d", i), 32'(wq[961 + i]), 32'(ent(1700 + i, i % 4)));
        end

        // 5: reset after 10 pixels of a 16x16 fill
        wq.delete(); d0 = done_cnt;
        send(0, 0, 16, 16, 2);
        g = 0;
        while (wq.size() < 10 && g < 100) begin tick(); g++; end
        chk("t5_pre_nwr", wq.size(), 10);
        rst = 1'b1;
        tick();
        chk("t5_rst_wr_en", 32'(bif.wr_en), 0);
        chk("t5_rst_busy",  32'(bif.busy), 0);
        chk("t5_rst_done",  32'(bif.done), 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("t5_no_more_wr", wq.size(), 10);
        chk("t5_no_done",    32'(done_cnt - d0), 0);
        send(1, 1, 1, 1, 1);
        wait_idle("t5_idle", 50);
        chk("t5_post_nwr", wq.size(), 11);
        if (wq.size() == 11) chk("t5_post_w", 32'(wq[10]), 32'(ent(321, 1)));
        chk("t5_post_done", 32'(done_cnt - d0), 1);

        // 6: push on the pop edge with three requests queued
        wq.delete(); d0 = done_cnt;
        send(0, 10, 8, 1, 1);
        send(200, 0, 1, 1, 2);
        send(201, 0, 1, 1, 3);
        send(202, 0, 1, 1, 0);
        wait_done(n);
        chk("t6_a_done", 32'(bif.done), 1);
        tick();
        set_req(203, 0, 1, 1, 1);
        bif.req_valid = 1'b1;
        chk("t6_ready_at3", 32'(bif.req_ready), 1);
        tick();
        bif.req_valid = 1'b0;
        chk("t6_ready_after", 32'(bif.req_ready), 1);
        wait_idle("t6_idle", 100);
        chk("t6_done_cnt", 32'(done_cnt - d0), 5);
        chk("t6_nwr", wq.size(), 12);
        if (wq.size() == 12) begin
            chk("t6_a_first", 32'(wq[0]), 32'(ent(3200, 1)));
            chk("t6_a_last",  32'(wq[7]), 32'(ent(3207, 1)));
            chk("t6_b", 32'(wq[8]),  32'(ent(200, 2)));
            chk("t6_c", 32'(wq[9]),  32'(ent(201, 3)));
            chk("t6_d", 32'(wq[10]), 32'(ent(202, 0)));
            chk("t6_e", 32'(wq[11]), 32'(ent(203, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
